// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline defines: EX forward-select encodings and the per-stage hazard record.
// The mul_div field exists only when HAZARD_MULDIV_EN is defined.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  localparam int unsigned MD_CNT_W = 4;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] write_reg;
    logic       reg_write;
    logic       mem_to_reg;
`ifdef HAZARD_MULDIV_EN
    logic       mul_div;
`endif
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  // Register 0 is hardwired, so a write to it never produces a dependency.
  function automatic logic reg_match(input logic [4:0] src,
                                     input logic [4:0] write_reg,
                                     input logic       reg_write);
    return reg_write && (write_reg != 5'd0) && (write_reg == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_stage_reg.sv
// One pipeline-stage copy of the hazard record: async clear, with bubble/load/hold control.
// Bubble takes priority over load; neither asserted holds the current contents.
module hazard_stage_reg
  import hazard_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  stage_t stage_d;
  stage_t stage_q;

  always_comb begin
    stage_d = stage_q;
    if (bubble) begin
      stage_d = STAGE_BUBBLE;
    end else if (load) begin
      stage_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= STAGE_BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, load-use/branch stalls and multi-cycle mul/div hold.
// Optional macro HAZARD_MULDIV_EN enables the mul/div occupancy counter and EX hold.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] WriteRegD,
  input  logic       RegWriteD,
  input  logic       MemtoRegD,
  input  logic       BranchD,
  input  logic       MulDivD,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE
);

  stage_t   d_stage;
  stage_t   ex_stage;
  stage_t   mem_stage;
  stage_t   wb_stage;
  logic     lwstall;
  logic     branchstall;
  logic     mdbusy;
  logic     flush_e;
  fwd_sel_e fwd_ae;
  fwd_sel_e fwd_be;

  always_comb begin
    d_stage            = STAGE_BUBBLE;
    d_stage.rs         = RsD;
    d_stage.rt         = RtD;
    d_stage.write_reg  = WriteRegD;
    d_stage.reg_write  = RegWriteD;
    d_stage.mem_to_reg = MemtoRegD;
`ifdef HAZARD_MULDIV_EN
    d_stage.mul_div    = MulDivD;
`endif
  end

`ifdef HAZARD_MULDIV_EN
  localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MULDIV_LAT - 1);

  logic [MD_CNT_W-1:0] md_cnt_d;
  logic [MD_CNT_W-1:0] md_cnt_q;

  // Counts completed EX cycles of the resident mul/div; stops at MD_LAST so it cannot wrap.
  always_comb begin
    mdbusy   = ex_stage.mul_div && (md_cnt_q < MD_LAST);
    md_cnt_d = '0;
    if (mdbusy) begin
      md_cnt_d = md_cnt_q + MD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  logic unused_md_fields;
  assign unused_md_fields = mem_stage.mul_div ^ wb_stage.mul_div;
`else
  assign mdbusy = 1'b0;

  logic unused_md_cfg;
  assign unused_md_cfg = MulDivD ^ (MULDIV_LAT == 32'd0);
`endif

  always_comb begin
    ForwardAD = reg_match(RsD, mem_stage.write_reg, mem_stage.reg_write);
    ForwardBD = reg_match(RtD, mem_stage.write_reg, mem_stage.reg_write);

    fwd_ae = FWD_NONE;
    if (reg_match(ex_stage.rs, mem_stage.write_reg, mem_stage.reg_write)) begin
      fwd_ae = FWD_MEM;
    end else if (reg_match(ex_stage.rs, wb_stage.write_reg, wb_stage.reg_write)) begin
      fwd_ae = FWD_WB;
    end

    fwd_be = FWD_NONE;
    if (reg_match(ex_stage.rt, mem_stage.write_reg, mem_stage.reg_write)) begin
      fwd_be = FWD_MEM;
    end else if (reg_match(ex_stage.rt, wb_stage.write_reg, wb_stage.reg_write)) begin
      fwd_be = FWD_WB;
    end
  end

  assign ForwardAE = fwd_ae;
  assign ForwardBE = fwd_be;

  always_comb begin
    lwstall = ex_stage.mem_to_reg &&
              (reg_match(RsD, ex_stage.write_reg, ex_stage.reg_write) ||
               reg_match(RtD, ex_stage.write_reg, ex_stage.reg_write));

    branchstall = BranchD &&
                  (reg_match(RsD, ex_stage.write_reg, ex_stage.reg_write) ||
                   reg_match(RtD, ex_stage.write_reg, ex_stage.reg_write) ||
                   (mem_stage.mem_to_reg &&
                    (reg_match(RsD, mem_stage.write_reg, mem_stage.reg_write) ||
                     reg_match(RtD, mem_stage.write_reg, mem_stage.reg_write))));

    // A busy mul/div holds EX in place, so it must suppress the bubble a load-use stall would insert.
    flush_e = (lwstall || branchstall) && !mdbusy;
  end

  assign StallF = lwstall || branchstall || mdbusy;
  assign StallD = lwstall || branchstall || mdbusy;
  assign FlushE = flush_e;

  hazard_stage_reg u_ex (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (!mdbusy),
    .bubble (flush_e),
    .d      (d_stage),
    .q      (ex_stage)
  );

  hazard_stage_reg u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (1'b1),
    .bubble (mdbusy),
    .d      (ex_stage),
    .q      (mem_stage)
  );

  hazard_stage_reg u_wb (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (1'b1),
    .bubble (1'b0),
    .d      (mem_stage),
    .q      (wb_stage)
  );

  logic unused_fields;
  assign unused_fields = ^{mem_stage.rs, mem_stage.rt,
                           wb_stage.rs, wb_stage.rt, wb_stage.mem_to_reg};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus random traffic
// checked against an instruction-level pipeline model.
module tb_hazard_ctrl;

  localparam int unsigned LAT = 4;
`ifdef HAZARD_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] RsD, RtD, WriteRegD;
  logic       RegWriteD, MemtoRegD, BranchD, MulDivD;
  logic       ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushE;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULDIV_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RsD       (RsD),
    .RtD       (RtD),
    .WriteRegD (WriteRegD),
    .RegWriteD (RegWriteD),
    .MemtoRegD (MemtoRegD),
    .BranchD   (BranchD),
    .MulDivD   (MulDivD),
    .ForwardAD (ForwardAD),
    .ForwardBD (ForwardBD),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushE    (FlushE)
  );

  // Instruction-level model: an in-flight instruction list plus cycles spent in EX.
  typedef struct {
    int rs;
    int rt;
    int wr;
    bit rw;
    bit mtr;
    bit br;
    bit md;
  } ins_t;

  ins_t bub;
  ins_t cur;
  ins_t ex_i, mem_i, wb_i;
  int   ex_age;

  function automatic bit dep(int src, ins_t p);
    return p.rw && (p.wr != 0) && (p.wr == src);
  endfunction

  function automatic void hazards(output bit lw, output bit br, output bit md);
    lw = ex_i.mtr && (dep(cur.rs, ex_i) || dep(cur.rt, ex_i));
    br = cur.br && (dep(cur.rs, ex_i) || dep(cur.rt, ex_i) ||
                    (mem_i.mtr && (dep(cur.rs, mem_i) || dep(cur.rt, mem_i))));
    md = MD_EN && ex_i.md && (ex_age + 1 < int'(LAT));
  endfunction

  function automatic logic [1:0] fwd_e(int src);
    if (dep(src, mem_i)) return 2'b10;
    if (dep(src, wb_i))  return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [9:0] model_out();
    bit lw, br, md, st, fl;
    hazards(lw, br, md);
    st = lw | br | md;
    fl = (lw | br) & ~md;
    return {1'b0, dep(cur.rs, mem_i), dep(cur.rt, mem_i),
            fwd_e(ex_i.rs), fwd_e(ex_i.rt), st, st, fl};
  endfunction

  function automatic logic [9:0] dut_out();
    return {1'b0, ForwardAD, ForwardBD, ForwardAE, ForwardBE, StallF, StallD, FlushE};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ex_i   = bub;
    mem_i  = bub;
    wb_i   = bub;
    ex_age = 0;
  endtask

  task automatic drive(input string tag, input int rs, input int rt, input int wr,
                       input bit rw, input bit mtr, input bit br, input bit md);
    cur.rs = rs; cur.rt = rt; cur.wr = wr;
    cur.rw = rw; cur.mtr = mtr; cur.br = br; cur.md = md & MD_EN;
    RsD = 5'(rs); RtD = 5'(rt); WriteRegD = 5'(wr);
    RegWriteD = rw; MemtoRegD = mtr; BranchD = br; MulDivD = md;
    #2;
    chk(tag, dut_out(), model_out());
  endtask

  task automatic tick();
    bit lw, br, md;
    hazards(lw, br, md);
    @(posedge clk);
    wb_i = mem_i;
    if (md) begin
      mem_i = bub;
      ex_age++;
    end else begin
      mem_i  = ex_i;
      ex_i   = (lw | br) ? bub : cur;
      ex_age = 0;
    end
    #1;
  endtask

  initial begin
    bub = '{default: 0};
    cur = bub;
    model_reset();
    rst_n = 1'b0;
    drive("reset_outputs", 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    #10;
    chk("reset_all_zero", dut_out(), 10'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // add r3 then dependent consumers; r0 never forwards
    drive("add_r3", 1, 2, 3, 1, 0, 0, 0);          tick();
    drive("sub_uses_r3", 3, 4, 6, 1, 0, 0, 0);     tick();
    drive("and_uses_r3", 3, 5, 8, 1, 0, 0, 0);
    chk("fwd_ae_mem", {8'd0, ForwardAE}, 10'b10);  tick();
    drive("nop", 0, 0, 0, 0, 0, 0, 0);
    chk("fwd_ae_wb", {8'd0, ForwardAE}, 10'b01);   tick();
    drive("add_r0", 1, 1, 0, 1, 0, 0, 0);          tick();
    drive("sub_uses_r0", 0, 0, 9, 1, 0, 0, 0);     tick();
    drive("nop", 0, 0, 0, 0, 0, 0, 0);
    chk("fwd_r0_none", {6'd0, ForwardAE, ForwardBE}, 10'd0); tick();

    // load-use
    drive("lw_r5", 1, 0, 5, 1, 1, 0, 0);           tick();
    drive("use_r5", 5, 2, 10, 1, 0, 0, 0);
    chk("lw_stall", {7'd0, StallF, StallD, FlushE}, 10'b111); tick();
    drive("use_r5_held", 5, 2, 10, 1, 0, 0, 0);
    chk("lw_release", {7'd0, StallF, StallD, FlushE}, 10'b000); tick();
    drive("nop", 0, 0, 0, 0, 0, 0, 0);
    chk("lw_fwd_wb", {8'd0, ForwardAE}, 10'b01);   tick();

    // branch compare in decode
    drive("add_r4", 1, 2, 4, 1, 0, 0, 0);          tick();
    drive("beq_r4", 4, 0, 0, 0, 0, 1, 0);
    chk("br_stall", {7'd0, StallF, StallD, FlushE}, 10'b111); tick();
    drive("beq_r4_held", 4, 0, 0, 0, 0, 1, 0);
    chk("br_fwd_ad", {6'd0, ForwardAD, StallF, StallD, FlushE}, 10'b1000); tick();
    drive("nop", 0, 0, 0, 0, 0, 0, 0);             tick();
    drive("nop", 0, 0, 0, 0, 0, 0, 0);             tick();

    // mul/div occupancy with a load and its consumer behind it
    drive("mult_r11", 1, 2, 11, 1, 0, 0, 1);       tick();
    for (int i = 0; i < int'(LAT) - 1; i++) begin
      drive("lw_r12_behind_md", 1, 0, 12, 1, 1, 0, 0);
      chk("md_stall", {7'd0, StallF, StallD, FlushE}, MD_EN ? 10'b110 : 10'b000);
      tick();
    end
    drive("lw_r12_enter", 1, 0, 12, 1, 1, 0, 0);
    chk("md_done", {7'd0, StallF, StallD, FlushE}, 10'b000); tick();
    drive("use_r12", 12, 1, 13, 1, 0, 0, 0);
    chk("lw_after_md", {7'd0, StallF, StallD, FlushE}, 10'b111); tick();
    drive("use_r12_held", 12, 1, 13, 1, 0, 0, 0);  tick();
    drive("nop", 0, 0, 0, 0, 0, 0, 0);             tick();

    // reset pulsed during a mul/div stall
    drive("mult_r11_b", 1, 2, 11, 1, 0, 0, 1);     tick();
    drive("behind_md", 11, 11, 15, 1, 0, 1, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", dut_out(), 10'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive("after_reset", 11, 11, 14, 1, 0, 1, 0);
    chk("no_stall_after_reset", {7'd0, StallF, StallD, FlushE}, 10'b000); tick();

    // random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      drive("random",
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
